// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator differencer.
// The optional statistics counters are enabled by ACC_DIFFERENCER_STATS_EN.
package acc_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int SUM_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Entry layout at the default widths; the top rebuilds the same shape at IN_W.
  typedef struct packed {
    logic [IN_W_DEF-1:0] data;
    logic                err;
  } acc_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/acc_skid_fifo.sv
// Two-entry output FIFO with registered valid/ready flags.
// The head register always holds the oldest entry so the consumer sees it directly.
module acc_skid_fifo
  import acc_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ready
);

  fifo_state_t  state_r;
  fifo_state_t  state_nxt_s;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         valid_r;
  logic         ready_r;
  logic         push_s;
  logic         pop_s;

  // Qualify push/pop against occupancy and derive the next occupancy state.
  always_comb begin
    push_s      = push & ready_r & ~clr;
    pop_s       = pop & valid_r & ~clr;
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) state_nxt_s = ONE;
          else        state_nxt_s = EMPTY;
        end
        ONE: begin
          if (push_s && !pop_s)      state_nxt_s = FULL;
          else if (!push_s && pop_s) state_nxt_s = EMPTY;
          else                       state_nxt_s = ONE;
        end
        FULL: begin
          if (pop_s) state_nxt_s = ONE;
          else       state_nxt_s = FULL;
        end
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // Occupancy, flags and entry storage; a pop from FULL shifts tail into head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= EMPTY;
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else if (clr) begin
      state_r <= EMPTY;
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != EMPTY);
      ready_r <= (state_nxt_s != FULL);
      case (state_r)
        EMPTY: begin
          if (push_s) head_r <= din;
        end
        ONE: begin
          if (push_s && pop_s) head_r <= din;
          else if (push_s)     tail_r <= din;
        end
        FULL: begin
          if (pop_s) head_r <= tail_r;
        end
        default: begin
          head_r <= {W{1'b0}};
          tail_r <= {W{1'b0}};
        end
      endcase
    end
  end

  assign dout  = head_r;
  assign valid = valid_r;
  assign ready = ready_r;

endmodule

// File: rtl/acc_differencer.sv
// Recovers input samples from an accumulator's running sum by first differencing.
// Define ACC_DIFFERENCER_STATS_EN to add saturating sample/error counters.
module acc_differencer
  import acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [SUM_W-1:0] sum,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [IN_W-1:0]  in,
  output logic             in_err,
  output logic             in_valid,
  input  logic             in_ready
`ifdef ACC_DIFFERENCER_STATS_EN
  ,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      err_cnt
`endif
);

  typedef struct packed {
    logic [IN_W-1:0] data;
    logic            err;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [SUM_W-1:0] prev_r;
  logic [SUM_W-1:0] delta_s;
  logic             err_s;
  logic             accept_s;
  entry_t           push_entry_s;
  entry_t           head_entry_s;

  // Modular difference against the previous sum; anything above IN_W bits is an error.
  always_comb begin
    delta_s           = sum - prev_r;
    err_s             = ((delta_s >> IN_W) != {SUM_W{1'b0}});
    accept_s          = sum_valid & sum_ready & ~clr;
    push_entry_s.data = delta_s[IN_W-1:0];
    push_entry_s.err  = err_s;
  end

  // Previous-sum history, advanced only on an accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r <= {SUM_W{1'b0}};
    end else if (clr) begin
      prev_r <= {SUM_W{1'b0}};
    end else if (accept_s) begin
      prev_r <= sum;
    end
  end

  acc_skid_fifo #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (accept_s),
    .pop   (in_ready),
    .din   (push_entry_s),
    .dout  (head_entry_s),
    .valid (in_valid),
    .ready (sum_ready)
  );

  assign in     = head_entry_s.data;
  assign in_err = head_entry_s.err;

`ifdef ACC_DIFFERENCER_STATS_EN
  logic [15:0] sample_cnt_r;
  logic [15:0] err_cnt_r;

  // Saturating statistics over accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_r <= 16'd0;
      err_cnt_r    <= 16'd0;
    end else if (clr) begin
      sample_cnt_r <= 16'd0;
      err_cnt_r    <= 16'd0;
    end else if (accept_s) begin
      sample_cnt_r <= sat_inc16(sample_cnt_r);
      if (err_s) err_cnt_r <= sat_inc16(err_cnt_r);
    end
  end

  assign sample_cnt = sample_cnt_r;
  assign err_cnt    = err_cnt_r;
`endif

endmodule

// File: tb/tb_acc_differencer.sv
// Self-checking bench for acc_differencer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_acc_differencer;

  localparam int IN_W  = 8;
  localparam int SUM_W = 16;
  localparam int MOD_SUM = 65536;
  localparam int MOD_IN  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [SUM_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ready;
  logic [IN_W-1:0]   dout;
  logic              dout_err;
  logic              dout_valid;
  logic              in_ready;
`ifdef ACC_DIFFERENCER_STATS_EN
  logic [15:0]       sample_cnt;
  logic [15:0]       err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int data;
    bit err;
  } exp_t;

  exp_t mq[$];
  int   mprev   = 0;
  int   m_samp  = 0;
  int   m_errs  = 0;

  always #5 clk = ~clk;

  acc_differencer #(.IN_W(IN_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .in        (dout),
    .in_err    (dout_err),
    .in_valid  (dout_valid),
    .in_ready  (in_ready)
`ifdef ACC_DIFFERENCER_STATS_EN
    ,
    .sample_cnt(sample_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic model_reset();
    mq.delete();
    mprev  = 0;
    m_samp = 0;
    m_errs = 0;
  endtask

  // Advance one clock edge and update the reference model from the pre-edge inputs.
  task automatic tick();
    bit   acc;
    bit   pp;
    int   d;
    exp_t e;
    acc = sum_valid && !clr && (mq.size() < 2);
    pp  = in_ready && !clr && (mq.size() > 0);
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        d = ((int'(sum) - mprev) % MOD_SUM + MOD_SUM) % MOD_SUM;
        e.data = d % MOD_IN;
        e.err  = (d >= MOD_IN);
        mq.push_back(e);
        mprev = int'(sum);
        if (m_samp < 65535) m_samp++;
        if (e.err && m_errs < 65535) m_errs++;
      end
    end
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    sum_valid = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; sum = '0; sum_valid = 1'b0; in_ready = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'd0 || dout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b in=%0d err=%0b want 0/0/0", dout_valid, dout, dout_err);
    end
    #21 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (sum_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%0b want=1", sum_ready);
    end
  endtask

  task automatic test_basic_sequence();
    int sums[4] = '{3, 10, 10, 265};
    int want[4] = '{3, 7, 0, 255};
    in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum = SUM_W'(sums[i]); sum_valid = 1'b1;
      tick();
      checks++;
      if (dout_valid !== 1'b1 || int'(dout) !== want[i] || dout_err !== 1'b0) begin
        failures++;
        $display("FAIL basic_seq[%0d] got valid=%0b in=%0d err=%0b want 1/%0d/0", i, dout_valid, dout, dout_err, want[i]);
      end
    end
    sum_valid = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain got valid=%0b want 0", dout_valid);
    end
  endtask

  task automatic test_overflow();
    pulse_clr();
    in_ready = 1'b1;
    sum = 16'd0; sum_valid = 1'b1; tick();
    sum = 16'd300; tick();
    sum_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'd44 || dout_err !== 1'b1) begin
      failures++;
      $display("FAIL overflow got valid=%0b in=%0d err=%0b want 1/44/1", dout_valid, dout, dout_err);
    end
`ifdef ACC_DIFFERENCER_STATS_EN
    checks++;
    if (sample_cnt !== 16'd2 || err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stats_overflow got samples=%0d errs=%0d want 2/1", sample_cnt, err_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    pulse_clr();
    in_ready = 1'b0;
    sum_valid = 1'b1;
    sum = 16'd1; tick();
    sum = 16'd2; tick();
    checks++;
    if (sum_ready !== 1'b0 || dout !== 8'd1) begin
      failures++;
      $display("FAIL bp_full got ready=%0b in=%0d want 0/1", sum_ready, dout);
    end
    sum = 16'd3; tick();
    checks++;
    if (sum_ready !== 1'b0 || dout_valid !== 1'b1 || dout !== 8'd1) begin
      failures++;
      $display("FAIL bp_hold got ready=%0b valid=%0b in=%0d want 0/1/1", sum_ready, dout_valid, dout);
    end
    in_ready = 1'b1; tick();
    checks++;
    if (sum_ready !== 1'b1 || dout !== 8'd1 || mq.size() != 1) begin
      failures++;
      $display("FAIL bp_first_pop got ready=%0b in=%0d want 1/1", sum_ready, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'd1 || dout_err !== 1'b0) begin
      failures++;
      $display("FAIL bp_third got valid=%0b in=%0d err=%0b want 1/1/0", dout_valid, dout, dout_err);
    end
    sum_valid = 1'b0; tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got valid=%0b want 0", dout_valid);
    end
  endtask

  task automatic test_wrap();
    pulse_clr();
    in_ready = 1'b1;
    sum = 16'hFFF0; sum_valid = 1'b1; tick();
    sum = 16'h0004; tick();
    checks++;
    if (dout !== 8'd20 || dout_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_20 got in=%0d err=%0b want 20/0", dout, dout_err);
    end
    sum = 16'hFFFE; tick();
    sum = 16'h0003; tick();
    checks++;
    if (dout !== 8'd5 || dout_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_5 got in=%0d err=%0b want 5/0", dout, dout_err);
    end
    sum_valid = 1'b0; tick();
  endtask

  task automatic test_clr();
    pulse_clr();
    in_ready = 1'b0;
    sum = 16'd5; sum_valid = 1'b1; tick();
    sum = 16'd7; clr = 1'b1; tick();
    clr = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || sum_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_flush got valid=%0b ready=%0b want 0/1", dout_valid, sum_ready);
    end
    in_ready = 1'b1; sum = 16'd9; tick();
    sum_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'd9 || dout_err !== 1'b0) begin
      failures++;
      $display("FAIL clr_next got valid=%0b in=%0d err=%0b want 1/9/0", dout_valid, dout, dout_err);
    end
    tick();
  endtask

  task automatic test_async_reset();
    in_ready = 1'b0;
    sum_valid = 1'b1;
    sum = 16'd40; tick();
    sum = 16'd50; tick();
    sum_valid = 1'b0;
    checks++;
    if (sum_ready !== 1'b0 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_fill got ready=%0b valid=%0b want 0/1", sum_ready, dout_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'd0) begin
      failures++;
      $display("FAIL areset_immediate got valid=%0b in=%0d want 0/0", dout_valid, dout);
    end
    #3 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (sum_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_ready got=%0b want 1", sum_ready);
    end
    tick();
    in_ready = 1'b1; sum = 16'd11; sum_valid = 1'b1; tick();
    sum_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'd11) begin
      failures++;
      $display("FAIL areset_first got valid=%0b in=%0d want 1/11", dout_valid, dout);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sum_valid = ($urandom_range(0, 3) != 0);
      in_ready  = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 29) == 0);
      sum       = SUM_W'($urandom);
      tick();
      checks++;
      if (dout_valid !== (mq.size() > 0) || sum_ready !== (mq.size() < 2)) begin
        failures++;
        $display("FAIL rand_flags[%0d] got valid=%0b ready=%0b want %0b/%0b", i, dout_valid, sum_ready, mq.size() > 0, mq.size() < 2);
      end else if (mq.size() > 0) begin
        if (int'(dout) !== mq[0].data || dout_err !== mq[0].err) begin
          failures++;
          $display("FAIL rand_data[%0d] got in=%0d err=%0b want %0d/%0b", i, dout, dout_err, mq[0].data, mq[0].err);
        end
      end
`ifdef ACC_DIFFERENCER_STATS_EN
      checks++;
      if (int'(sample_cnt) !== m_samp || int'(err_cnt) !== m_errs) begin
        failures++;
        $display("FAIL rand_stats[%0d] got %0d/%0d want %0d/%0d", i, sample_cnt, err_cnt, m_samp, m_errs);
      end
`endif
    end
    clr = 1'b0;
    sum_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_overflow();
    test_backpressure();
    test_wrap();
    test_clr();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_differencer.md
ACC_DIFFERENCER -- requirements
Module: acc_differencer

Interface
REQ-001 The module SHALL have parameter IN_W, default 8, giving the width of each recovered input sample.
REQ-002 The module SHALL have parameter SUM_W, default 16, giving the width of each running-sum sample; SUM_W >= IN_W.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port clr, input, 1 bit: synchronous flush of all history and buffered data.
REQ-006 The module SHALL have port sum, input, SUM_W bits: running-sum sample as produced by the accumulator.
REQ-007 The module SHALL have port sum_valid, input, 1 bit: the sum port holds a sample.
REQ-008 The module SHALL have port sum_ready, output, 1 bit: the block can take a sample this cycle.
REQ-009 The module SHALL have port in, output, IN_W bits: recovered input sample, low IN_W bits of the delta.
REQ-010 The module SHALL have port in_err, output, 1 bit: the delta for the current in does not fit IN_W unsigned bits.
REQ-011 The module SHALL have port in_valid, output, 1 bit: in and in_err are valid.
REQ-012 The module SHALL have port in_ready, input, 1 bit: the consumer takes in this cycle.

Function
REQ-013 A sample SHALL be accepted on any rising edge where sum_valid and sum_ready are both high and clr is low.
REQ-014 On accept, the module SHALL compute delta = (sum - prev) mod 2^SUM_W, then load prev with sum.
REQ-015 in_err SHALL be 1 iff delta >= 2^IN_W.
REQ-016 On accept, {delta[IN_W-1:0], in_err} SHALL be pushed into a 2-entry output FIFO.
REQ-017 Latency: a sample accepted at edge N SHALL appear on in/in_valid after edge N, provided the FIFO was empty.
REQ-018 The FIFO SHALL have states EMPTY, ONE and FULL, with the following transitions:
- push only: state +1;
- pop only (in_valid and in_ready): state -1;
- push and pop together: state unchanged.
REQ-019 sum_ready SHALL be high in states EMPTY and ONE and low in FULL.
- Full-state accept is never possible, even when in_ready is high.
REQ-020 in_valid SHALL be high in states ONE and FULL.
- in/in_err SHALL show the oldest entry.
- in/in_err SHALL be held stable until popped.
REQ-021 Order SHALL be preserved; no entry is dropped or duplicated.
REQ-022 Subtraction SHALL wrap modulo 2^SUM_W.
- Example: sum wrap from 0xFFFE to 0x0003 gives delta 5, in_err 0.
REQ-023 clr high SHALL, at the next edge:
- set prev to 0;
- empty the FIFO;
- cancel any coincident accept or pop.
clr has priority over everything except rst.

Reset
REQ-024 When rst is low, the module SHALL immediately set:
- prev to 0 and FIFO state to EMPTY;
- in_valid 0, in 0, in_err 0;
- sum_ready 1 once rst is released.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered entries; the first sample after reset SHALL yield delta = sum.

Configuration
REQ-026 With macro ACC_DIFFERENCER_STATS_EN defined, the module SHALL add two outputs:
- sample_cnt, 16 bits: accepted samples;
- err_cnt, 16 bits: accepts with in_err = 1.
Both counters SHALL saturate at 0xFFFF and be cleared by rst and clr.
REQ-027 Without ACC_DIFFERENCER_STATS_EN, those ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package acc_pkg SHALL hold:
- default widths IN_W_DEF and SUM_W_DEF;
- enum fifo_state_t {EMPTY, ONE, FULL};
- the packed FIFO entry struct {data, err}.
REQ-029 The 2-entry FIFO SHALL be sub-module acc_skid_fifo, parameterised on entry type width; delta and in_err generation stay in acc_differencer.

Verification
REQ-030 After reset, with in_ready 1, the bench SHALL drive sums 3, 10, 10, 265:
- required outputs: in = 3, 7, 0, then 255 with in_err 0;
- each appears one cycle after its accept.
REQ-031 Sums 0 then 300 SHALL produce in = 44 (300 mod 256) with in_err 1; with STATS_EN, err_cnt = 1 and sample_cnt = 2.
REQ-032 With in_ready 0 and sum_valid 1 (sums 1, 2, 3):
- sum_ready SHALL drop after two accepts;
- raising in_ready SHALL yield in = 1 then 1, and the third sum is accepted only after the first pop.
REQ-033 Sum 0xFFF0 then 0x0004 SHALL produce a second in = 20 with in_err 0.
REQ-034 clr pulsed with a FIFO entry pending and sum_valid high SHALL:
- drop the entry and not accept the coincident sum;
- next sum 9 SHALL yield in = 9.
REQ-035 rst asserted asynchronously between clock edges while in state FULL SHALL immediately force in_valid 0, with sum_ready 1 once rst is released.
